// File: rtl/sync_counter_bank_pkg.sv
// Shared constants and helpers for the counter bank: direction encodings,
// default geometry and the saturating clamp used when loading a channel.
package counter_pkg;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int DEF_CH  = 4;
  localparam int DEF_W   = 4;
  localparam int DEF_MOD = 10;

  // Compared at 32 bits so that MOD = 2^W never overflows the channel width.
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] mod);
    return (v < mod) ? v : (mod - 32'd1);
  endfunction

endpackage

// File: rtl/sync_counter_bank_if.sv
// Control and data bundle of the counter bank.
// Handshake: none; en/load/dir/cascade/load_val are level inputs sampled on every rising clk edge,
// q/wrap are registered, tc is combinational from q and dir.
interface sync_counter_bank_if #(
  parameter int CH = 4,
  parameter int W  = 4
);
  logic            en;
  logic            dir;
  logic            cascade;
  logic            load;
  logic [CH*W-1:0] load_val;
  logic [CH*W-1:0] q;
  logic [CH-1:0]   wrap;
  logic            tc;

  modport master (output en, dir, cascade, load, load_val, input q, wrap, tc);
  modport slave  (input en, dir, cascade, load, load_val, output q, wrap, tc);
endinterface

// File: rtl/sync_counter_bank_digit.sv
// One modulo-MOD channel: load with clamp, up/down step with wrap flag,
// and a combinational terminal-value indication for the current direction.
module counter_digit
  import counter_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int MOD = DEF_MOD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         dir,
  output logic [W-1:0] q,
  output logic         is_term,
  output logic         wrap
);

  localparam logic [W-1:0] TOP_V = W'(MOD - 1);

  logic [W-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;

  assign is_term = (dir == DIR_UP) ? (q_q == TOP_V) : (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = W'(clamp(32'(load_val), 32'(MOD)));
    end else if (step) begin
      // Leaving the terminal value is exactly what counts as a wrap.
      wrap_d = is_term;
      if (is_term) q_d = (dir == DIR_UP) ? '0 : TOP_V;
      else         q_d = (dir == DIR_UP) ? (q_q + W'(1)) : (q_q - W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/sync_counter_bank.sv
// Bank of CH modulo-MOD counters, either chained into one multi-digit counter
// (cascade=1) or stepping independently (cascade=0).
module sync_counter_bank
  import counter_pkg::*;
#(
  parameter int CH  = DEF_CH,
  parameter int W   = DEF_W,
  parameter int MOD = DEF_MOD
) (
  input logic               clk,
  input logic               rst,
  sync_counter_bank_if.slave bus
);

  logic [CH-1:0]   is_term;
  logic [CH-1:0]   step;
  logic [CH-1:0]   wrap_all;
  logic [CH*W-1:0] q_all;
  // carry[i] = all channels below i sit at their terminal value; carry[CH] is tc.
  logic [CH:0]     carry;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < CH; g++) begin : g_digit
    assign carry[g+1] = carry[g] & is_term[g];
    assign step[g]    = bus.en & (bus.cascade ? carry[g] : 1'b1);

    counter_digit #(.W(W), .MOD(MOD)) u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (bus.load),
      .load_val (bus.load_val[g*W +: W]),
      .step     (step[g]),
      .dir      (bus.dir),
      .q        (q_all[g*W +: W]),
      .is_term  (is_term[g]),
      .wrap     (wrap_all[g])
    );
  end

  assign bus.q    = q_all;
  assign bus.wrap = wrap_all;
  assign bus.tc   = carry[CH];

endmodule

// File: tb/tb_sync_counter_bank.sv
// Bench for sync_counter_bank (CH=4, W=4, MOD=10): value-level model checked every
// cycle, plus literal expectations on the directed scenarios.
module tb_sync_counter_bank;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int MOD  = 10;
  localparam int NTOT = MOD * MOD * MOD * MOD;

  logic clk;
  logic rst;
  sync_counter_bank_if #(.CH(CH), .W(W)) bus ();

  sync_counter_bank #(.CH(CH), .W(W), .MOD(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- behavioural model ----------------
  int            m_d [CH];
  logic [CH-1:0] m_w;
  logic          chk_en = 1'b0;
  int            mv, mp, lv;
  logic [CH-1:0] nw;

  always @(posedge clk) begin
    nw = '0;
    if (rst) begin
      for (int i = 0; i < CH; i++) m_d[i] = 0;
    end else if (bus.load) begin
      for (int i = 0; i < CH; i++) begin
        lv     = int'(bus.load_val[i*W +: W]);
        m_d[i] = (lv < MOD) ? lv : MOD - 1;
      end
    end else if (bus.en) begin
      if (bus.cascade) begin
        // Treat the bank as one base-MOD number.
        mv = 0;
        for (int i = CH - 1; i >= 0; i--) mv = mv * MOD + m_d[i];
        mp = 1;
        for (int i = 0; i < CH; i++) begin
          mp    = mp * MOD;
          nw[i] = bus.dir ? ((mv % mp) == 0) : ((mv % mp) == mp - 1);
        end
        mv = bus.dir ? (mv + NTOT - 1) % NTOT : (mv + 1) % NTOT;
        for (int i = 0; i < CH; i++) begin
          m_d[i] = mv % MOD;
          mv     = mv / MOD;
        end
      end else begin
        for (int i = 0; i < CH; i++) begin
          nw[i]  = bus.dir ? (m_d[i] == 0) : (m_d[i] == MOD - 1);
          m_d[i] = bus.dir ? (m_d[i] + MOD - 1) % MOD : (m_d[i] + 1) % MOD;
        end
      end
    end
    m_w    = nw;
    chk_en = 1'b1;
  end

  // ---------------- scoreboard compare ----------------
  logic [CH*W-1:0] exp_q;
  logic            exp_tc;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_tc = 1'b1;
      for (int i = 0; i < CH; i++) begin
        exp_q[i*W +: W] = W'(m_d[i]);
        if (m_d[i] != (bus.dir ? 0 : MOD - 1)) exp_tc = 1'b0;
      end
      nvec++;
      if (bus.q !== exp_q) begin
        nerr++;
        $display("FAIL model_q t=%0t got=%h exp=%h", $time, bus.q, exp_q);
      end
      nvec++;
      if (bus.wrap !== m_w) begin
        nerr++;
        $display("FAIL model_wrap t=%0t got=%b exp=%b", $time, bus.wrap, m_w);
      end
      nvec++;
      if (bus.tc !== exp_tc) begin
        nerr++;
        $display("FAIL model_tc t=%0t got=%b exp=%b", $time, bus.tc, exp_tc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic l, input logic [CH*W-1:0] v,
                       input logic e, input logic d, input logic c);
    rst          = r;
    bus.load     = l;
    bus.load_val = v;
    bus.en       = e;
    bus.dir      = d;
    bus.cascade  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [CH*W-1:0] eq,
                           input logic [CH-1:0] ew);
    nvec++;
    if (bus.q !== eq || bus.wrap !== ew) begin
      nerr++;
      $display("FAIL %s got q=%h wrap=%b exp q=%h wrap=%b", name, bus.q, bus.wrap, eq, ew);
    end
  endtask

  task automatic check_tc(input string name, input logic etc);
    nvec++;
    if (bus.tc !== etc) begin
      nerr++;
      $display("FAIL %s got tc=%b exp tc=%b", name, bus.tc, etc);
    end
  endtask

  // ---------------- directed stimulus ----------------
  int w3_cnt;
  int w3_at;

  initial begin
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 16'h1234;
    bus.en = 1'b1; bus.dir = 1'b0; bus.cascade = 1'b1;

    // reset dominates load and en
    drive(1, 1, 16'h1234, 1, 0, 1);
    drive(1, 1, 16'h1234, 1, 0, 1);
    check_lit("reset", 16'h0000, 4'b0000);
    drive(0, 0, 16'h0000, 1, 0, 1);
    check_lit("reset_release", 16'h0001, 4'b0000);

    // cascade up carry
    drive(0, 1, 16'h0999, 0, 0, 1);
    check_lit("load_0999", 16'h0999, 4'b0000);
    drive(0, 0, 16'h0000, 1, 0, 1);
    check_lit("carry_1000", 16'h1000, 4'b0111);
    drive(0, 0, 16'h0000, 0, 0, 1);
    check_lit("wrap_clear", 16'h1000, 4'b0000);
    drive(0, 1, 16'h9999, 0, 0, 1);
    check_tc("tc_9999_up", 1'b1);
    drive(0, 0, 16'h0000, 1, 0, 1);
    check_lit("carry_0000", 16'h0000, 4'b1111);

    // cascade down borrow
    drive(0, 1, 16'h0000, 0, 1, 1);
    check_tc("tc_0000_dn", 1'b1);
    drive(0, 0, 16'h0000, 1, 1, 1);
    check_lit("borrow_9999", 16'h9999, 4'b1111);
    drive(0, 1, 16'h1000, 0, 1, 1);
    drive(0, 0, 16'h0000, 1, 1, 1);
    check_lit("borrow_0999", 16'h0999, 4'b0111);

    // independent channels; channel 1 wraps in both directions
    drive(0, 1, 16'h0395, 0, 0, 0);
    drive(0, 0, 16'h0000, 1, 0, 0);
    check_lit("indep_up", 16'h1406, 4'b0010);
    drive(0, 0, 16'h0000, 1, 1, 0);
    check_lit("indep_dn", 16'h0395, 4'b0010);

    // clamp and load-over-en priority
    drive(0, 1, 16'hC3F2, 0, 0, 1);
    check_lit("clamp", 16'h9392, 4'b0000);
    drive(0, 1, 16'h0123, 1, 0, 1);
    check_lit("load_beats_en", 16'h0123, 4'b0000);

    // reset mid-count with en high
    drive(0, 0, 16'h0000, 1, 0, 1);
    drive(1, 0, 16'h0000, 1, 0, 1);
    check_lit("reset_mid", 16'h0000, 4'b0000);

    // full cascade sweep
    drive(0, 1, 16'h0000, 0, 0, 1);
    w3_cnt = 0;
    w3_at  = -1;
    for (int k = 1; k <= NTOT; k++) begin
      drive(0, 0, 16'h0000, 1, 0, 1);
      if (bus.wrap[3] === 1'b1) begin
        w3_cnt++;
        w3_at = k;
      end
    end
    check_lit("sweep_end", 16'h0000, 4'b1111);
    nvec++;
    if (w3_cnt != 1 || w3_at != NTOT) begin
      nerr++;
      $display("FAIL sweep_wrap3 got count=%0d at=%0d exp count=1 at=%0d", w3_cnt, w3_at, NTOT);
    end

    drive(0, 0, 16'h0000, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
